// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder, one CHUNK-bit slice per clock.
// Optional macro SEQ_CHUNK_ADDER_SUB_EN adds a 'sub' port (a + ~b + 1).
//
// Ports:
//   clk, rst_n     rising-edge clock, async active-low reset
//   start          request, sampled only while busy=0
//   a, b, cin      operands and carry-in, captured on accepted start
//   sub            (macro only) subtract, captured on accepted start
//   busy           operation in progress
//   done           one-cycle pulse, result valid
//   sum, cout      registered result, held until next accepted start
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             done_q;
    logic [IW-1:0]    idx_q;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK:0]   csum;

    // Subtraction folds into the adder: invert b on capture, seed carry 1.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign a_s  = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign b_s  = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign csum = {1'b0, a_s} + {1'b0, b_s}
                + {{CHUNK{1'b0}}, carry_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    last    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_in;
                carry_q <= c_in;
                idx_q   <= '0;
                sum_q   <= '0;
                cout_q  <= 1'b0;
            end else if (state_q == RUN) begin
                sum_q[int'(idx_q)*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
                carry_q <= csum[CHUNK];
                if (last) begin
                    idx_q  <= '0;
                    cout_q <= csum[CHUNK];
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: vectors, random ops vs arithmetic model,
// handshake, mid-op reset, 4-bit legacy and optional subtract cases.
module tb_seq_chunk_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic         sub;
    logic         sub4;
`endif

    logic         start4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         cin4;
    logic         busy4;
    logic         done4;
    logic [3:0]   sum4;
    logic         cout4;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .cin(cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, output logic [W-1:0] rs,
                          output logic rc, output int lat);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= N + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        rs = sum;
        rc = cout;
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tc, input logic [3:0] es,
                        input logic ec);
        int lat;
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = i;
                break;
            end
        end
        check("leg_lat", 32'(lat), 32'd1);
        check("leg_sum", 32'(sum4), 32'(es));
        check("leg_cout", 32'(cout4), 32'(ec));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        logic [W:0]   ref_full;
        int           pulses;

        vecs[0] = '{16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = 1'b0; sub4 = 1'b0;
`endif

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_sum4", 32'(sum4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(N));
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].es));
            check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].ec));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_clr", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(sum), 32'(vecs[i].es));
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rcin;
            ra = W'($urandom);
            rb = W'($urandom);
            rcin = 1'($urandom);
            if (i < 4) rb = ~ra;
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            run_op(ra, rb, rcin, rs, rc, lat);
            check("rnd_lat", 32'(lat), 32'(N));
            check("rnd_sum", 32'(rs), 32'(ref_full[W-1:0]));
            check("rnd_cout", 32'(rc), 32'(ref_full[W]));
        end

        // start held high: second op must begin on the edge after done
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        a = 16'h0100;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("hs_done_k%0d", k), 32'(done),
                  32'((k == 4) || (k == 9)));
            if (k == 4) check("hs_sum1", 32'(sum), 32'h0003);
            if (k == 5) check("hs_busy2", 32'(busy), 32'd1);
            if (k == 9) begin
                check("hs_sum2", 32'(sum), 32'h0102);
                start = 1'b0;
            end
        end
        @(posedge clk); #1;

        // asynchronous reset two cycles into an operation
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        run_op(16'h1111, 16'h2222, 1'b1, rs, rc, lat);
        check("post_rst_lat", 32'(lat), 32'(N));
        check("post_rst_sum", 32'(rs), 32'h3334);
        check("post_rst_cout", 32'(rc), 32'd0);

        run4(4'b0011, 4'b1100, 1'b1, 4'b0000, 1'b1);
        run4(4'b0010, 4'b1010, 1'b1, 4'b1101, 1'b0);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b1, rs, rc, lat);
        check("sub1_sum", 32'(rs), 32'hFFFE);
        check("sub1_cout", 32'(rc), 32'd0);
        run_op(16'h0007, 16'h0005, 1'b0, rs, rc, lat);
        check("sub2_sum", 32'(rs), 32'h0002);
        check("sub2_cout", 32'(rc), 32'd1);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
